// File: rtl/bpsk_symbol_mapper_if.sv
// Bit-in / sample-out handshake bundle for the BPSK symbol mapper.
// The master modport is the environment side (bit source and sample sink);
// the slave modport is the mapper itself.
interface bpsk_symbol_mapper_if #(
    parameter int DATA_WIDTH = 18
);
    logic                         bit_valid;
    logic                         bit_in;
    logic                         bit_ready;
    logic                         sample_valid;
    logic                         sample_ready;
    logic signed [DATA_WIDTH-1:0] sample_out;
    logic                         symbol_start;

    modport master (
        output bit_valid,
        output bit_in,
        output sample_ready,
        input  bit_ready,
        input  sample_valid,
        input  sample_out,
        input  symbol_start
    );

    modport slave (
        input  bit_valid,
        input  bit_in,
        input  sample_ready,
        output bit_ready,
        output sample_valid,
        output sample_out,
        output symbol_start
    );
endinterface

// File: rtl/bpsk_symbol_mapper.sv
// BPSK symbol mapper: each accepted bit becomes SAMPLES_PER_SYMBOL signed
// samples of +AMPLITUDE (bit 1) or -AMPLITUDE (bit 0). Within a continuous
// back-to-back stream, the first sample of a symbol whose polarity differs
// from the previous symbol is replaced by zero to soften the transition.
module bpsk_symbol_mapper #(
    parameter int SAMPLES_PER_SYMBOL = 8,
    parameter int DATA_WIDTH         = 18,
    parameter int AMPLITUDE          = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    bpsk_symbol_mapper_if.slave   bus,
    output logic                  busy
);

    localparam int IDX_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
    localparam logic [IDX_W-1:0]             IDX_LAST = IDX_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic signed [DATA_WIDTH-1:0] POS_AMP  = DATA_WIDTH'(AMPLITUDE);
    localparam logic signed [DATA_WIDTH-1:0] NEG_AMP  = -POS_AMP;

    // Reject parameter sets that would overflow the sample width or
    // leave no room for a transition sample.
    if (SAMPLES_PER_SYMBOL < 2 || AMPLITUDE <= 0 ||
        AMPLITUDE >= (1 << (DATA_WIDTH - 1))) begin : g_bad_params
        $error("bpsk_symbol_mapper: illegal SAMPLES_PER_SYMBOL/AMPLITUDE/DATA_WIDTH");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         cur_bit_q, cur_bit_d;
    logic                         prev_bit_q, prev_bit_d;
    logic                         b2b_q, b2b_d;
    logic signed [DATA_WIDTH-1:0] sample_q, sample_d;

    logic bit_ready_s;
    logic bit_hs_s;
    logic smp_hs_s;
    logic last_s;

    // Full-scale level for a data bit.
    function automatic logic signed [DATA_WIDTH-1:0] level_f(input logic b);
        return b ? POS_AMP : NEG_AMP;
    endfunction

    assign last_s      = (idx_q == IDX_LAST);
    assign bit_ready_s = !rst && ((state_q == ST_IDLE) || (last_s && bus.sample_ready));
    assign bit_hs_s    = bus.bit_valid && bit_ready_s;
    assign smp_hs_s    = (state_q == ST_EMIT) && bus.sample_ready;

    // Next-state logic: sequence samples, chain the next bit on the last sample.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_bit_d  = cur_bit_q;
        prev_bit_d = prev_bit_q;
        b2b_d      = b2b_q;
        sample_d   = sample_q;
        case (state_q)
            ST_IDLE: begin
                if (bit_hs_s) begin
                    cur_bit_d = bus.bit_in;
                    idx_d     = '0;
                    b2b_d     = 1'b0;
                    state_d   = ST_EMIT;
                    // A symbol that starts from idle never gets a zero.
                    sample_d  = level_f(bus.bit_in);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (!smp_hs_s) begin
                    state_d = ST_EMIT;
                end else if (!last_s) begin
                    idx_d    = idx_q + IDX_W'(1);
                    sample_d = level_f(cur_bit_q);
                end else begin
                    prev_bit_d = cur_bit_q;
                    if (bit_hs_s) begin
                        cur_bit_d = bus.bit_in;
                        idx_d     = '0;
                        b2b_d     = 1'b1;
                        state_d   = ST_EMIT;
                        sample_d  = (bus.bit_in != cur_bit_q) ? '0 : level_f(bus.bit_in);
                    end else begin
                        idx_d    = '0;
                        b2b_d    = 1'b0;
                        state_d  = ST_IDLE;
                        sample_d = '0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                idx_d    = '0;
                b2b_d    = 1'b0;
                sample_d = '0;
            end
        endcase
    end

    // State and sample registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cur_bit_q  <= 1'b0;
            prev_bit_q <= 1'b0;
            b2b_q      <= 1'b0;
            sample_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_bit_q  <= cur_bit_d;
            prev_bit_q <= prev_bit_d;
            b2b_q      <= b2b_d;
            sample_q   <= sample_d;
        end
    end

    assign bus.bit_ready    = bit_ready_s;
    assign bus.sample_valid = (state_q == ST_EMIT);
    assign bus.sample_out   = sample_q;
    assign bus.symbol_start = (state_q == ST_EMIT) && (idx_q == '0);
    assign busy             = (state_q == ST_EMIT);

endmodule

// File: tb/tb_bpsk_symbol_mapper.sv
// Directed testbench for bpsk_symbol_mapper (8 samples/symbol, 18-bit, A=65536).
module tb_bpsk_symbol_mapper;

    logic clk;
    logic rst;
    logic busy;
    int   tests_run;
    int   tests_failed;

    bpsk_symbol_mapper_if #(.DATA_WIDTH(18)) bus ();

    bpsk_symbol_mapper #(
        .SAMPLES_PER_SYMBOL(8),
        .DATA_WIDTH(18),
        .AMPLITUDE(65536)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus.bit_valid    = 1'b1;
        bus.bit_in       = 1'b1;
        bus.sample_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            tests_run++;
            if (bus.bit_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_bit_ready c=%0d: got %b want 0", c, bus.bit_ready);
            end
            tests_run++;
            if (bus.sample_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_sample_valid c=%0d: got %b want 0", c, bus.sample_valid);
            end
            tests_run++;
            if (bus.sample_out !== 18'h00000) begin
                tests_failed++;
                $display("FAIL reset_sample_out c=%0d: got %h want 00000", c, bus.sample_out);
            end
            tests_run++;
            if (busy !== 1'b0 || bus.symbol_start !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_busy_sstart c=%0d: got %b%b want 00", c, busy, bus.symbol_start);
            end
        end
        rst           = 1'b0;
        bus.bit_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_bit();
        tick();
        bus.bit_valid    = 1'b1;
        bus.bit_in       = 1'b1;
        bus.sample_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.bit_ready !== 1'b1 || bus.sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: got ready=%b valid=%b want 1 0", bus.bit_ready, bus.sample_valid);
        end
        tick();
        bus.bit_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++;
            if (bus.sample_valid !== 1'b1 || bus.sample_out !== 18'h10000) begin
                tests_failed++;
                $display("FAIL single_sample i=%0d: got valid=%b out=%h want 1 10000", i, bus.sample_valid, bus.sample_out);
            end
            tests_run++;
            if (bus.symbol_start !== (i == 0) || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_sstart i=%0d: got sstart=%b busy=%b want %b 1", i, bus.symbol_start, busy, (i == 0));
            end
            tick();
        end
        #1;
        tests_run++;
        if (bus.sample_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_end: got valid=%b busy=%b want 0 0", bus.sample_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic        bits [4];
        logic [17:0] first_v [4];
        logic [17:0] rest_v [4];
        logic        chain;
        bits    = '{1'b1, 1'b0, 1'b0, 1'b1};
        first_v = '{18'h10000, 18'h00000, 18'h30000, 18'h00000};
        rest_v  = '{18'h10000, 18'h30000, 18'h30000, 18'h10000};
        tick();
        bus.sample_ready = 1'b1;
        bus.bit_valid    = 1'b1;
        bus.bit_in       = bits[0];
        tick();
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 8; i++) begin
                chain         = (i == 7) && (s < 3);
                bus.bit_valid = chain;
                bus.bit_in    = chain ? bits[(s < 3) ? s + 1 : 0] : 1'b0;
                #1;
                tests_run++;
                if (bus.sample_valid !== 1'b1 ||
                    bus.sample_out !== ((i == 0) ? first_v[s] : rest_v[s])) begin
                    tests_failed++;
                    $display("FAIL b2b_sample s=%0d i=%0d: got valid=%b out=%h want 1 %h", s, i,
                             bus.sample_valid, bus.sample_out, (i == 0) ? first_v[s] : rest_v[s]);
                end
                tests_run++;
                if (bus.symbol_start !== (i == 0) || bus.bit_ready !== (i == 7)) begin
                    tests_failed++;
                    $display("FAIL b2b_ctrl s=%0d i=%0d: got sstart=%b ready=%b want %b %b", s, i,
                             bus.symbol_start, bus.bit_ready, (i == 0), (i == 7));
                end
                tick();
            end
        end
        bus.bit_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: got valid=%b want 0", bus.sample_valid);
        end
    endtask

    task automatic test_gap();
        tick();
        bus.sample_ready = 1'b1;
        bus.bit_valid    = 1'b1;
        bus.bit_in       = 1'b0;
        tick();
        bus.bit_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++;
            if (bus.sample_valid !== 1'b1 || bus.sample_out !== 18'h30000 || bus.symbol_start !== (i == 0)) begin
                tests_failed++;
                $display("FAIL gap_first i=%0d: got valid=%b out=%h sstart=%b want 1 30000 %b", i,
                         bus.sample_valid, bus.sample_out, bus.symbol_start, (i == 0));
            end
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            #1;
            tests_run++;
            if (bus.sample_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL gap_idle g=%0d: got valid=%b busy=%b want 0 0", g, bus.sample_valid, busy);
            end
            tick();
        end
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++;
            if (bus.sample_valid !== 1'b1 || bus.sample_out !== 18'h10000 || bus.symbol_start !== (i == 0)) begin
                tests_failed++;
                $display("FAIL gap_second i=%0d: got valid=%b out=%h sstart=%b want 1 10000 %b", i,
                         bus.sample_valid, bus.sample_out, bus.symbol_start, (i == 0));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic pat [4];
        int   hs;
        logic done;
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        hs   = 0;
        done = 1'b0;
        tick();
        bus.sample_ready = 1'b1;
        bus.bit_valid    = 1'b1;
        bus.bit_in       = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            bus.sample_ready = pat[c % 4];
            #1;
            if (!bus.sample_valid) begin
                done = 1'b1;
            end else begin
                tests_run++;
                if (bus.sample_out !== 18'h10000 || bus.symbol_start !== (hs == 0)) begin
                    tests_failed++;
                    $display("FAIL bp_sample c=%0d hs=%0d: got out=%h sstart=%b want 10000 %b", c, hs,
                             bus.sample_out, bus.symbol_start, (hs == 0));
                end
                tests_run++;
                if (bus.bit_ready !== (bus.sample_ready && hs == 7)) begin
                    tests_failed++;
                    $display("FAIL bp_bit_ready c=%0d hs=%0d: got %b want %b", c, hs,
                             bus.bit_ready, (bus.sample_ready && hs == 7));
                end
                if (bus.sample_ready) hs++;
            end
            tick();
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL bp_timeout: got still valid after 64 cycles want idle");
        end
        tests_run++;
        if (hs != 8) begin
            tests_failed++;
            $display("FAIL bp_handshakes: got %0d want 8", hs);
        end
        bus.sample_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        tick();
        bus.sample_ready = 1'b1;
        bus.bit_valid    = 1'b1;
        bus.bit_in       = 1'b0;
        tick();
        bus.bit_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.sample_out !== 18'h30000 || bus.symbol_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_first: got out=%h sstart=%b want 30000 1", bus.sample_out, bus.symbol_start);
        end
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.bit_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_ready_in_rst: got %b want 0", bus.bit_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.sample_valid !== 1'b0 || bus.sample_out !== 18'h00000 ||
            busy !== 1'b0 || bus.symbol_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_cleared: got valid=%b out=%h busy=%b sstart=%b want 0 00000 0 0",
                     bus.sample_valid, bus.sample_out, busy, bus.symbol_start);
        end
        tick();
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++;
            if (bus.sample_valid !== 1'b1 || bus.sample_out !== 18'h10000 || bus.symbol_start !== (i == 0)) begin
                tests_failed++;
                $display("FAIL rmid_after i=%0d: got valid=%b out=%h sstart=%b want 1 10000 %b", i,
                         bus.sample_valid, bus.sample_out, bus.symbol_start, (i == 0));
            end
            tick();
        end
        #1;
        tests_run++;
        if (bus.sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_end: got valid=%b want 0", bus.sample_valid);
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b1;
        bus.bit_valid    = 1'b0;
        bus.bit_in       = 1'b0;
        bus.sample_ready = 1'b1;
        test_reset();
        test_single_bit();
        test_back_to_back();
        test_gap();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
